dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 32, address width; DWIDTH, default 32, data width; BASE_ADDR, default 32'h01000000, first valid byte address; DEPTH_BYTES, default 1048576, storage size in bytes; LATENCY, default 2, accept-to-response cycles, legal range 1..15.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept
- req_we_i  input  1  1 = store, 0 = load
- req_size_i  input  3  funct3 encoding: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr_i  input  AWIDTH  byte address
- req_wdata_i  input  DWIDTH  store data, right-aligned
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  initiator takes response
- rsp_rdata_o  output  DWIDTH  load data, extended; 0 for stores and errors
- rsp_err_o  output  1  misaligned, out-of-range or illegal size

Function
REQ-010 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-011 req_ready_o SHALL equal (state == IDLE); at most one transaction is outstanding.
REQ-012 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both 1. All request fields SHALL be captured on that edge, and the state SHALL go IDLE->BUSY with the counter loaded to LATENCY-1.
REQ-013 In BUSY, the counter SHALL decrement each cycle. When it is 0, the state SHALL go BUSY->RESP on the next edge, so rsp_valid_o first reads 1 exactly LATENCY cycles after acceptance.
REQ-014 A store SHALL commit to storage on the BUSY->RESP edge, and only if rsp_err_o will be 0.
REQ-015 Load data SHALL be sampled on the same edge, after any commit on that edge.
REQ-016 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_ready_i is 1. On that edge the state SHALL go RESP->IDLE.
REQ-017 The next request SHALL NOT be accepted in the same cycle as the response handshake (minimum 1 idle cycle).
REQ-018 An access SHALL be an error when any of these holds: the halfword address is odd; the word address is not a multiple of 4; any addressed byte lies outside [BASE_ADDR, BASE_ADDR+DEPTH_BYTES); req_size_i is 011, 110, 111, or 1xx with req_we_i = 1.
REQ-019 An error response SHALL still follow the normal latency. It SHALL write nothing and return rsp_rdata_o = 0.
REQ-020 Storage SHALL be little-endian. LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
REQ-021 SB and SH SHALL write only the addressed bytes from the low bytes of the captured wdata.
REQ-022 Store responses SHALL return rsp_rdata_o = 0 and rsp_err_o = 0 on success.
REQ-023 Address offset arithmetic SHALL be unsigned AWIDTH-bit subtraction of BASE_ADDR. Wrap-below-base SHALL count as out-of-range.
REQ-024 req_* inputs outside the acceptance edge SHALL be ignored.

Reset
REQ-030 While rst_n = 0, the state SHALL be IDLE, the counter 0, and all captured fields 0.
REQ-031 While rst_n = 0, outputs SHALL be: req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0. After deassertion, req_ready_o = 1 from the first cycle.
REQ-032 Reset asserted in BUSY SHALL abort the transaction, and an uncommitted store SHALL NOT be written.
REQ-033 Reset asserted in RESP SHALL drop the pending response.
REQ-034 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-040 The size encodings (MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTEU, MEM_HALFU) and the state enum type SHALL live in the shared constants package.
REQ-041 Byte-lane alignment, extension and error detection SHALL be a combinational sub-module named mem_lane_fmt. It SHALL be instantiated once for load formatting and once for store byte-enable generation.
REQ-042 Storage SHALL be a byte array sized DEPTH_BYTES with no read-port reset.

Verification
REQ-050 SW addr 0x01000010 data 0xDEADBEEF, then LW same address -> rsp_rdata_o = 0xDEADBEEF, err 0; each rsp_valid_o rises exactly 2 cycles after its acceptance.
REQ-051 SB 0x80 to 0x01000013, then LB and LBU at 0x01000013 -> 0xFFFFFF80 and 0x00000080; LW 0x01000010 -> 0x80ADBEEF.
REQ-052 LH at 0x01000011 -> err 1 and rdata 0; SW to 0x00FFFFFC -> err 1, and a following LW at 0x01000000 is unchanged.
REQ-053 Hold rsp_ready_i = 0 for 5 cycles -> response fields stable and req_ready_o = 0 throughout; a request offered meanwhile is accepted only after the handshake plus 1 idle cycle.
REQ-054 Pulse rst_n low during BUSY of SW 0x12345678 to 0x01000020 -> no response appears, and a later LW at 0x01000020 returns the pre-store value.
REQ-055 With LATENCY = 1, back-to-back LW requests -> responses 1 cycle after acceptance and an accept rate of one request per 3 cycles.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: access size encodings,
// FSM state type and a size-to-byte-count helper.
package dmem_responder_pkg;

    // funct3-style access size encodings
    localparam logic [2:0] MEM_BYTE  = 3'b000;
    localparam logic [2:0] MEM_HALF  = 3'b001;
    localparam logic [2:0] MEM_WORD  = 3'b010;
    localparam logic [2:0] MEM_BYTEU = 3'b100;
    localparam logic [2:0] MEM_HALFU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of bytes touched by an access; 0 marks an illegal encoding.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        logic [2:0] n;
        case (size)
            MEM_BYTE, MEM_BYTEU: n = 3'd1;
            MEM_HALF, MEM_HALFU: n = 3'd2;
            MEM_WORD:            n = 3'd4;
            default:             n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter: access error detection, store byte
// enables and lane placement, load lane extraction and sign/zero extension.
module mem_lane_fmt
    import dmem_responder_pkg::*;
#(
    parameter int unsigned       AWIDTH      = 32,
    parameter int unsigned       DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000),
    parameter int unsigned       DEPTH_BYTES = 1048576
) (
    input  logic                we,
    input  logic [2:0]          size,
    input  logic [AWIDTH-1:0]   addr,
    input  logic [DWIDTH-1:0]   data,
    output logic                err,
    output logic [AWIDTH-1:0]   offset,
    output logic [DWIDTH/8-1:0] be,
    output logic [DWIDTH-1:0]   wlanes,
    output logic [DWIDTH-1:0]   rdata
);

    localparam int NB = DWIDTH / 8;
    localparam int LW = $clog2(NB);
    localparam logic [AWIDTH:0] DEPTH_EXT = (AWIDTH+1)'(DEPTH_BYTES);

    logic [2:0]        nbytes_s;
    logic [LW-1:0]     lane_s;
    logic [AWIDTH:0]   end_s;
    logic              size_bad_s;
    logic              misal_s;
    logic              range_bad_s;
    logic [NB-1:0]     be_base_s;
    logic [DWIDTH-1:0] shifted_s;

    assign nbytes_s  = size_bytes(size);
    assign lane_s    = addr[LW-1:0];
    // Unsigned wrap makes addresses below the base look huge, hence out of range
    assign offset    = addr - BASE_ADDR;
    assign end_s     = {1'b0, offset} + (AWIDTH+1)'(nbytes_s);
    assign wlanes    = data << {lane_s, 3'b000};
    assign shifted_s = data >> {lane_s, 3'b000};

    // Classify the access: illegal size, misalignment or out-of-range bytes
    always_comb begin
        size_bad_s  = (nbytes_s == 3'd0) || (we && size[2]);
        misal_s     = ((nbytes_s == 3'd2) && addr[0]) ||
                      ((nbytes_s == 3'd4) && (addr[1:0] != 2'b00));
        range_bad_s = (end_s > DEPTH_EXT);
        err         = size_bad_s | misal_s | range_bad_s;
    end

    // Byte enables for the addressed lanes, suppressed on error
    always_comb begin
        case (nbytes_s)
            3'd1:    be_base_s = NB'(4'b0001);
            3'd2:    be_base_s = NB'(4'b0011);
            3'd4:    be_base_s = NB'(4'b1111);
            default: be_base_s = NB'(4'b0000);
        endcase
        if (err) begin
            be = NB'(4'b0000);
        end else begin
            be = be_base_s << lane_s;
        end
    end

    // Load result: extract addressed lanes and extend; zero on error or store
    always_comb begin
        rdata = DWIDTH'(1'b0);
        if (!err && !we) begin
            case (size)
                MEM_BYTE:  rdata = DWIDTH'($signed(shifted_s[7:0]));
                MEM_HALF:  rdata = DWIDTH'($signed(shifted_s[15:0]));
                MEM_WORD:  rdata = DWIDTH'(shifted_s[31:0]);
                MEM_BYTEU: rdata = DWIDTH'(shifted_s[7:0]);
                MEM_HALFU: rdata = DWIDTH'(shifted_s[15:0]);
                default:   rdata = DWIDTH'(1'b0);
            endcase
        end else begin
            rdata = DWIDTH'(1'b0);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed accept-to-response
// latency, little-endian byte storage and error reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned       AWIDTH      = 32,
    parameter int unsigned       DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000),
    parameter int unsigned       DEPTH_BYTES = 1048576,
    parameter int unsigned       LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_size_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int NB   = DWIDTH / 8;
    localparam int LW   = $clog2(NB);
    localparam int IDXW = $clog2(DEPTH_BYTES);

    state_t            state_r, state_nx;
    logic [3:0]        cnt_r, cnt_nx;
    logic              we_r;
    logic [2:0]        size_r;
    logic [AWIDTH-1:0] addr_r;
    logic [DWIDTH-1:0] wdata_r;
    logic [DWIDTH-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    logic              accept_s;
    logic              finish_s;
    logic              handshake_s;
    logic              commit_s;

    logic [7:0]        mem [DEPTH_BYTES];
    logic [DWIDTH-1:0] rword_s;
    logic [IDXW-1:0]   rd_base_s;
    logic [IDXW-1:0]   wr_base_s;

    logic              err_ld_s, err_st_s;
    logic [AWIDTH-1:0] offset_ld_s, offset_st_s;
    logic [NB-1:0]     be_ld_s, be_st_s;
    logic [DWIDTH-1:0] wlanes_ld_s, wlanes_st_s;
    logic [DWIDTH-1:0] rdata_ld_s, rdata_st_s;
    logic              unused_s;

    assign accept_s    = req_valid_i && (state_r == IDLE);
    assign finish_s    = (state_r == BUSY) && (cnt_r == 4'd0);
    assign handshake_s = (state_r == RESP) && rsp_ready_i;
    assign commit_s    = finish_s && we_r && !err_st_s;

    assign req_ready_o = rst_n && (state_r == IDLE);
    assign rsp_valid_o = (state_r == RESP);
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;

    // Both paths only ever touch bytes inside one aligned word
    assign rd_base_s = {offset_ld_s[IDXW-1:LW], {LW{1'b0}}};
    assign wr_base_s = {offset_st_s[IDXW-1:LW], {LW{1'b0}}};

    // Formatter outputs not needed on the respective path
    assign unused_s = ^{be_ld_s, wlanes_ld_s, rdata_st_s, offset_ld_s, offset_st_s};

    mem_lane_fmt #(
        .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
        .BASE_ADDR(BASE_ADDR), .DEPTH_BYTES(DEPTH_BYTES)
    ) u_load_fmt (
        .we(we_r), .size(size_r), .addr(addr_r), .data(rword_s),
        .err(err_ld_s), .offset(offset_ld_s), .be(be_ld_s),
        .wlanes(wlanes_ld_s), .rdata(rdata_ld_s)
    );

    mem_lane_fmt #(
        .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
        .BASE_ADDR(BASE_ADDR), .DEPTH_BYTES(DEPTH_BYTES)
    ) u_store_fmt (
        .we(we_r), .size(size_r), .addr(addr_r), .data(wdata_r),
        .err(err_st_s), .offset(offset_st_s), .be(be_st_s),
        .wlanes(wlanes_st_s), .rdata(rdata_st_s)
    );

    // FSM state and latency counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_valid_i) begin
                    state_nx = BUSY;
                    cnt_nx   = 4'(LATENCY - 1);
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = RESP;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Capture all request fields on the acceptance edge only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            size_r  <= 3'b000;
            addr_r  <= AWIDTH'(1'b0);
            wdata_r <= DWIDTH'(1'b0);
        end else if (accept_s) begin
            we_r    <= req_we_i;
            size_r  <= req_size_i;
            addr_r  <= req_addr_i;
            wdata_r <= req_wdata_i;
        end
    end

    // Response registers: loaded on BUSY->RESP, cleared on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_r <= DWIDTH'(1'b0);
            rsp_err_r   <= 1'b0;
        end else if (finish_s) begin
            rsp_rdata_r <= rdata_ld_s;
            rsp_err_r   <= err_ld_s;
        end else if (handshake_s) begin
            rsp_rdata_r <= DWIDTH'(1'b0);
            rsp_err_r   <= 1'b0;
        end
    end

    // Gather the aligned storage word around the captured address
    always_comb begin
        rword_s = DWIDTH'(1'b0);
        for (int b = 0; b < NB; b++) begin
            rword_s[b*8 +: 8] = mem[rd_base_s + IDXW'(b)];
        end
    end

    // Store commit of enabled byte lanes; storage has no reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int b = 0; b < NB; b++) begin
                if (be_st_s[b]) begin
                    mem[wr_base_s + IDXW'(b)] <= wlanes_st_s[b*8 +: 8];
                end
            end
        end
    end

endmodule
